// File: rtl/shift_reg_stimulus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : shift_reg_stimulus_pkg                                     |
// | Purpose  : Shared definitions for the shift-register stimulus block.  |
// |            Holds the register mode encodings, the sequencer state     |
// |            encodings and the LFSR tap positions.                      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package shift_reg_stimulus_pkg;

  // Register mode encodings, shared by both register implementations
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Sequencer states
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SHR  = 3'd2;
  localparam state_t ST_SHL  = 3'd3;
  localparam state_t ST_HOLD = 3'd4;
  localparam state_t ST_DIS  = 3'd5;
  localparam state_t ST_FIN  = 3'd6;

  // x^4 + x^3 + 1: feedback is q[3] ^ q[2], shifted in at the LSB
  localparam int LFSR_TAP_HI = 3;
  localparam int LFSR_TAP_LO = 2;

endpackage
`default_nettype wire

// File: rtl/shift_reg_stimulus_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : shift_reg_stimulus_if                                      |
// | Purpose  : Control and data bundle between the stimulus sequencer     |
// |            (master/writer) and the shift register (slave/reader).     |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface shift_reg_stimulus_if #(
  parameter int WIDTH = 4
);
  logic             START;
  logic             STALL;
  logic             ENB;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic             S_IN;
  logic             BUSY;
  logic             DONE;

  // Sequencer side: takes run control, drives the register inputs
  modport master (
    input  START, STALL,
    output ENB, MODO, D, S_IN, BUSY, DONE
  );

  // Register side: consumes the generated stimulus
  modport slave (
    input  ENB, MODO, D, S_IN, BUSY, DONE
  );
endinterface
`default_nettype wire

// File: rtl/shift_reg_stimulus_lfsr_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : lfsr_gen                                                   |
// | Purpose  : Fibonacci LFSR producing pseudo-random register data.      |
// |            Loads SEED on request, otherwise steps when advanced.      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module lfsr_gen
  import shift_reg_stimulus_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(4'b1011)
) (
  input  wire logic             CLK,
  input  wire logic             RESET,
  input  wire logic             load,
  input  wire logic             advance,
  output      logic [WIDTH-1:0] q
);

  // Shift left, feedback bit enters at the LSB; load wins over advance
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q <= '0;
    end else if (load) begin
      q <= SEED;
    end else if (advance) begin
      q <= {q[WIDTH-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_reg_stimulus.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : shift_reg_stimulus                                         |
// | Purpose  : Self-running stimulus sequencer for the 4-bit universal    |
// |            shift register. Walks LOAD, SHR, SHL, HOLD, DIS for a      |
// |            number of passes with LFSR data, then pulses DONE.         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module shift_reg_stimulus
  import shift_reg_stimulus_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter logic [WIDTH-1:0] SEED            = WIDTH'(4'b1011),
  parameter int               CYCLES_PER_MODE = 8,
  parameter int               NUM_PASSES      = 2
) (
  input  wire logic           CLK,
  input  wire logic           RESET,
  shift_reg_stimulus_if.master bus
);

  localparam int PH_W = $clog2(CYCLES_PER_MODE) + 1;
  localparam int PS_W = $clog2(NUM_PASSES) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLES_PER_MODE - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(NUM_PASSES - 1);

  state_t            state, state_next;
  logic [PH_W-1:0]   phase_cnt, phase_next;
  logic [PS_W-1:0]   pass_cnt, pass_next;
  logic              lfsr_load, lfsr_adv;
  logic [WIDTH-1:0]  lfsr_q, lfsr_after;

  logic              enb_next, busy_next, done_next;
  logic [1:0]        modo_next;
  logic [WIDTH-1:0]  d_next;
  logic              enb_r, busy_r, done_r;
  logic [1:0]        modo_r;
  logic [WIDTH-1:0]  d_r;

  lfsr_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  // Value the LFSR will hold after this edge; D mirrors it so D stays registered
  assign lfsr_after = lfsr_load ? SEED :
                      lfsr_adv  ? {lfsr_q[WIDTH-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]} :
                                  lfsr_q;

  // State and counter register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      pass_cnt  <= '0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_next;
      pass_cnt  <= pass_next;
    end
  end

  // Next-state: phase sequencing, pass counting, LFSR control; STALL freezes all
  always_comb begin
    state_next = state;
    phase_next = phase_cnt;
    pass_next  = pass_cnt;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    if (state == ST_IDLE) begin
      if (bus.START) begin
        state_next = ST_LOAD;
        phase_next = '0;
        pass_next  = '0;
        lfsr_load  = 1'b1;
      end
    end else if (!bus.STALL) begin
      if (state == ST_FIN) begin
        state_next = ST_IDLE;
        phase_next = '0;
        pass_next  = '0;
      end else begin
        lfsr_adv = 1'b1;
        if (phase_cnt == PH_LAST) begin
          phase_next = '0;
          case (state)
            ST_LOAD: state_next = ST_SHR;
            ST_SHR:  state_next = ST_SHL;
            ST_SHL:  state_next = ST_HOLD;
            ST_HOLD: state_next = ST_DIS;
            ST_DIS: begin
              pass_next = pass_cnt + 1'b1;
              if (pass_cnt == PS_LAST) begin
                // Last cycle of the run: the data word is left where it is
                state_next = ST_FIN;
                lfsr_adv   = 1'b0;
              end else begin
                state_next = ST_LOAD;
              end
            end
            default: state_next = ST_IDLE;
          endcase
        end else begin
          phase_next = phase_cnt + 1'b1;
        end
      end
    end
  end

  // Output decode from the upcoming state, so outputs register with the state
  always_comb begin
    enb_next  = 1'b0;
    modo_next = MODE_HOLD;
    busy_next = 1'b1;
    done_next = 1'b0;
    case (state_next)
      ST_LOAD: begin enb_next = 1'b1; modo_next = MODE_LOAD; end
      ST_SHR:  begin enb_next = 1'b1; modo_next = MODE_SHR;  end
      ST_SHL:  begin enb_next = 1'b1; modo_next = MODE_SHL;  end
      ST_HOLD: begin enb_next = 1'b1; modo_next = MODE_HOLD; end
      ST_DIS:  begin enb_next = 1'b0; modo_next = MODE_LOAD; end
      ST_FIN:  done_next = 1'b1;
      default: busy_next = 1'b0;
    endcase
    d_next = (state_next == ST_IDLE) ? '0 : lfsr_after;
  end

  // Output register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      enb_r  <= 1'b0;
      modo_r <= MODE_HOLD;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      d_r    <= '0;
    end else begin
      enb_r  <= enb_next;
      modo_r <= modo_next;
      busy_r <= busy_next;
      done_r <= done_next;
      d_r    <= d_next;
    end
  end

  assign bus.ENB  = enb_r;
  assign bus.MODO = modo_r;
  assign bus.D    = d_r;
  assign bus.S_IN = d_r[0];
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_stimulus.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_shift_reg_stimulus                                      |
// | Purpose  : Self-checking bench for shift_reg_stimulus: vector table,  |
// |            model-checked runs with stalls, restarts and resets.       |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_shift_reg_stimulus;
  import shift_reg_stimulus_pkg::*;

  localparam int         W      = 4;
  localparam logic [3:0] SEED_V = 4'b1011;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  shift_reg_stimulus_if #(.WIDTH(W)) bus_a ();
  shift_reg_stimulus_if #(.WIDTH(W)) bus_b ();

  shift_reg_stimulus #(.WIDTH(W), .SEED(SEED_V), .CYCLES_PER_MODE(8), .NUM_PASSES(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a.master));

  shift_reg_stimulus #(.WIDTH(W), .SEED(SEED_V), .CYCLES_PER_MODE(1), .NUM_PASSES(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b.master));

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] seq [15];

  typedef struct {
    logic       start;
    logic       stall;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Packed view: {BUSY, DONE, ENB, MODO, D, S_IN}
  function automatic logic [9:0] pk(input logic b, input logic dn, input logic e,
                                    input logic [1:0] m, input logic [3:0] d, input logic s);
    return {b, dn, e, m, d, s};
  endfunction

  function automatic logic [9:0] get_out(input int sel);
    if (sel == 1)
      return {bus_b.BUSY, bus_b.DONE, bus_b.ENB, bus_b.MODO, bus_b.D, bus_b.S_IN};
    return {bus_a.BUSY, bus_a.DONE, bus_a.ENB, bus_a.MODO, bus_a.D, bus_a.S_IN};
  endfunction

  // LFSR rule in arithmetic form: shift left, new LSB = bit3 xor bit2
  function automatic logic [3:0] lfsr_next_model(input logic [3:0] x);
    int v, b3, b2;
    v  = int'(x);
    b3 = v / 8;
    b2 = (v / 4) % 2;
    return 4'(((v * 2) % 16) + ((b3 + b2) % 2));
  endfunction

  // Expected outputs at unstalled run position k (k = 0 is the first BUSY cycle)
  function automatic logic [9:0] exp_out(input int k, input int c, input int p);
    int total, phase;
    logic [3:0] d;
    logic [1:0] m;
    total = 5 * c * p;
    if (k > total) return '0;
    if (k == total) begin
      d = seq[(total - 1) % 15];
      return pk(1'b1, 1'b1, 1'b0, MODE_HOLD, d, d[0]);
    end
    phase = (k / c) % 5;
    d = seq[k % 15];
    case (phase)
      0:       m = MODE_LOAD;
      1:       m = MODE_SHR;
      2:       m = MODE_SHL;
      3:       m = MODE_HOLD;
      default: m = MODE_LOAD;
    endcase
    return pk(1'b1, 1'b0, (phase != 4), m, d, d[0]);
  endfunction

  task automatic drive(input logic st, input logic sl);
    bus_a.START = st; bus_a.STALL = sl;
    bus_b.START = st; bus_b.STALL = sl;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    check("reset_idle_a", get_out(0), 10'd0);
    check("reset_idle_b", get_out(1), 10'd0);
  endtask

  // stall_mode: 0 none, 1 three cycles at SHL cycle 4, 2 random
  // start_mode: 0 single pulse, 1 held high, 2 random during the run
  task automatic run_model(input int sel, input int c, input int p,
                           input int stall_mode, input int start_mode, input string tag);
    int k, total, busy_n, done_n, stall_n, stall_left, cyc;
    bit stalled_once;
    logic st, sr;
    logic [9:0] out;
    total = 5 * c * p;
    k = 0; busy_n = 0; done_n = 0; stall_n = 0; stall_left = 0; cyc = 0;
    stalled_once = 0;
    drive(1'b1, 1'b0);
    @(posedge CLK); #1;
    while (cyc < 2000) begin
      out = get_out(sel);
      check($sformatf("%s_k%0d", tag, k), out, exp_out(k, c, p));
      if (p > 1 && k == 5 * c)
        check($sformatf("%s_pass2_d", tag), out[4:1], seq[(5 * c) % 15]);
      if (out[9]) busy_n++;
      if (out[8]) done_n++;
      if (k == total + 1) break;
      st = 1'b0;
      if (k < total) begin
        if (stall_mode == 1 && !stalled_once && k == 2 * c + 3) begin
          stall_left = 3;
          stalled_once = 1;
        end
        if (stall_left > 0) begin
          st = 1'b1;
          stall_left--;
        end
        if (stall_mode == 2) st = ($urandom % 4 == 0);
      end
      if (st) stall_n++;
      case (start_mode)
        1:       sr = 1'b1;
        2:       sr = 1'($urandom % 2);
        default: sr = 1'b0;
      endcase
      drive(sr, st);
      @(posedge CLK); #1;
      cyc++;
      if (!st) k++;
    end
    check($sformatf("%s_in_time", tag), 32'(cyc < 2000), 32'd1);
    check($sformatf("%s_busy_len", tag), busy_n, total + 1 + stall_n);
    check($sformatf("%s_done_cnt", tag), done_n, 1);
    if (start_mode == 1) begin
      // START still high in IDLE: the next edge begins a fresh run
      @(posedge CLK); #1;
      check($sformatf("%s_restart", tag), get_out(sel), exp_out(0, c, p));
    end
    drive(1'b0, 1'b0);
  endtask

  initial begin
    int done_n, busy_n;
    seq[0] = SEED_V;
    for (int i = 1; i < 15; i++) seq[i] = lfsr_next_model(seq[i-1]);

    drive(1'b0, 1'b0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state_a", get_out(0), 10'd0);
    check("reset_state_b", get_out(1), 10'd0);
    RESET = 1'b0;

    // Start-up vectors on the default instance
    tbl[0] = '{1'b0, 1'b0, pk(0, 0, 0, MODE_HOLD, 4'b0000, 0)};
    tbl[1] = '{1'b0, 1'b1, pk(0, 0, 0, MODE_HOLD, 4'b0000, 0)};
    tbl[2] = '{1'b1, 1'b0, pk(1, 0, 1, MODE_LOAD, 4'b1011, 1)};
    tbl[3] = '{1'b0, 1'b0, pk(1, 0, 1, MODE_LOAD, 4'b0111, 1)};
    tbl[4] = '{1'b1, 1'b0, pk(1, 0, 1, MODE_LOAD, 4'b1111, 1)};
    tbl[5] = '{1'b0, 1'b1, pk(1, 0, 1, MODE_LOAD, 4'b1111, 1)};
    tbl[6] = '{1'b0, 1'b0, pk(1, 0, 1, MODE_LOAD, 4'b1110, 0)};
    tbl[7] = '{1'b0, 1'b0, pk(1, 0, 1, MODE_LOAD, 4'b1100, 0)};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].start, tbl[i].stall);
      @(posedge CLK); #1;
      check($sformatf("vec%0d", i), get_out(0), tbl[i].exp);
    end

    do_reset();
    run_model(0, 8, 2, 0, 0, "full");
    do_reset();
    run_model(0, 8, 2, 1, 0, "stall");
    do_reset();
    run_model(0, 8, 2, 2, 2, "random");
    do_reset();
    run_model(0, 8, 2, 0, 1, "b2b");

    // Asynchronous reset in the middle of HOLD
    do_reset();
    drive(1'b1, 1'b0);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0);
    repeat (26) begin @(posedge CLK); #1; end
    check("pre_reset_hold", get_out(0), exp_out(26, 8, 2));
    #2 RESET = 1'b1;
    #1 check("async_reset", get_out(0), 10'd0);
    @(posedge CLK); #1 RESET = 1'b0;
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (bus_a.DONE) done_n++;
      if (bus_a.BUSY) busy_n++;
    end
    check("no_done_after_reset", done_n, 0);
    check("no_busy_after_reset", busy_n, 0);
    run_model(0, 8, 2, 0, 0, "restart");

    // Minimal configuration
    do_reset();
    run_model(1, 1, 1, 0, 0, "sweep");
    do_reset();
    run_model(1, 1, 1, 2, 1, "sweep_b2b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
